// File: rtl/bsr_layer_sequencer.sv
// Multi-layer load/compute scheduler: drives bsr_dma through per-layer SEL/START CSR writes
// and ping-pongs two weight banks so that the next layer loads while the current one computes.
module bsr_layer_sequencer #(
   parameter int unsigned MAX_LAYERS     = 8,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seq_start,
   input  logic        seq_abort,
   input  logic [3:0]  cfg_num_layers,
   input  logic        cfg_word_mode,
   output logic [7:0]  dma_csr_addr,
   output logic        dma_csr_wen,
   output logic [31:0] dma_csr_wdata,
   input  logic        dma_busy,
   input  logic        dma_done,
   input  logic        dma_error,
   output logic        load_bank,
   output logic        comp_start,
   output logic [2:0]  comp_layer,
   output logic        comp_bank,
   input  logic        comp_done,
   output logic        seq_busy,
   output logic        seq_done,
   output logic        seq_error,
   output logic [1:0]  retry_count
);

   localparam logic [3:0]  LP_MAX_LAYERS = 4'(MAX_LAYERS);
   localparam logic [1:0]  LP_MAX_RETRY  = 2'(MAX_RETRY);
   localparam logic [31:0] LP_TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  LP_CSR_SEL    = 8'h50;
   localparam logic [7:0]  LP_CSR_CTRL   = 8'h51;

   typedef enum logic [2:0] {L_IDLE, L_WAITBANK, L_SEL, L_GO, L_WAIT, L_NEXT} lstate_t;
   typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RUN} cstate_t;

   lstate_t     r_lst;
   cstate_t     r_cst;
   logic [2:0]  r_lyr;
   logic [2:0]  r_cly;
   logic [3:0]  r_num;
   logic        r_word_mode;
   logic [1:0]  r_retry;
   logic [31:0] r_tmo;
   logic [1:0]  r_bank_full;
   logic [7:0]  r_csr_addr;
   logic        r_csr_wen;
   logic [31:0] r_csr_wdata;
   logic        r_load_bank;
   logic        r_comp_start;
   logic [2:0]  r_comp_layer;
   logic        r_comp_bank;
   logic        r_seq_busy;
   logic        r_seq_done;
   logic        r_seq_error;

   logic [3:0]  w_num_clamp;
   logic        w_start;
   logic        w_ld_fail;
   logic        w_ld_ok;
   logic        w_fatal;
   logic        w_abort;
   logic [1:0]  w_bank_set;
   logic [1:0]  w_bank_clr;
   logic [3:0]  w_lyr_next;
   logic [3:0]  w_cly_next;
   logic        w_unused;

   assign w_unused    = dma_busy;
   assign w_num_clamp = (cfg_num_layers > LP_MAX_LAYERS) ? LP_MAX_LAYERS : cfg_num_layers;
   assign w_start     = seq_start && !r_seq_busy && !seq_abort;
   // A timeout counts as an error, and an error beats a simultaneous done.
   assign w_ld_fail   = (r_lst == L_WAIT) && (dma_error || (r_tmo == LP_TMO_LAST));
   assign w_ld_ok     = (r_lst == L_WAIT) && dma_done && !w_ld_fail;
   assign w_fatal     = w_ld_fail && (r_retry == LP_MAX_RETRY);
   assign w_abort     = seq_abort || w_fatal;
   assign w_bank_set  = w_ld_ok ? (r_lyr[0] ? 2'b10 : 2'b01) : 2'b00;
   assign w_bank_clr  = ((r_cst == C_RUN) && comp_done) ? (r_cly[0] ? 2'b10 : 2'b01) : 2'b00;
   assign w_lyr_next  = {1'b0, r_lyr} + 4'd1;
   assign w_cly_next  = {1'b0, r_cly} + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lst        <= L_IDLE;
         r_cst        <= C_IDLE;
         r_lyr        <= '0;
         r_cly        <= '0;
         r_num        <= '0;
         r_word_mode  <= 1'b0;
         r_retry      <= '0;
         r_tmo        <= '0;
         r_bank_full  <= '0;
         r_csr_addr   <= '0;
         r_csr_wen    <= 1'b0;
         r_csr_wdata  <= '0;
         r_load_bank  <= 1'b0;
         r_comp_start <= 1'b0;
         r_comp_layer <= '0;
         r_comp_bank  <= 1'b0;
         r_seq_busy   <= 1'b0;
         r_seq_done   <= 1'b0;
         r_seq_error  <= 1'b0;
      end else begin
         r_csr_wen    <= 1'b0;
         r_comp_start <= 1'b0;
         r_seq_done   <= 1'b0;
         if (w_abort) begin
            r_lst       <= L_IDLE;
            r_cst       <= C_IDLE;
            r_bank_full <= '0;
            r_seq_busy  <= 1'b0;
            r_retry     <= '0;
            if (w_fatal)
               r_seq_error <= 1'b1;
         end else begin
            r_bank_full <= (r_bank_full & ~w_bank_clr) | w_bank_set;
            // Banks are always empty when idle, so the first SEL write needs no bank wait.
            if (w_start) begin
               r_seq_error <= 1'b0;
               r_num       <= w_num_clamp;
               r_word_mode <= cfg_word_mode;
               r_lyr       <= '0;
               r_cly       <= '0;
               r_retry     <= '0;
               if (w_num_clamp == 4'd0) begin
                  r_seq_done <= 1'b1;
               end else begin
                  r_seq_busy  <= 1'b1;
                  r_lst       <= L_SEL;
                  r_cst       <= C_WAIT;
                  r_csr_wen   <= 1'b1;
                  r_csr_addr  <= LP_CSR_SEL;
                  r_csr_wdata <= '0;
                  r_load_bank <= 1'b0;
               end
            end

            case (r_lst)
               L_WAITBANK: begin
                  if (!r_bank_full[r_lyr[0]]) begin
                     r_lst       <= L_SEL;
                     r_csr_wen   <= 1'b1;
                     r_csr_addr  <= LP_CSR_SEL;
                     r_csr_wdata <= {29'b0, r_lyr};
                     r_load_bank <= r_lyr[0];
                  end
               end
               L_SEL: begin
                  r_lst       <= L_GO;
                  r_csr_wen   <= 1'b1;
                  r_csr_addr  <= LP_CSR_CTRL;
                  r_csr_wdata <= {29'b0, r_word_mode, 2'b01};
               end
               L_GO: begin
                  r_lst <= L_WAIT;
                  r_tmo <= '0;
               end
               L_WAIT: begin
                  if (w_ld_fail) begin
                     r_retry     <= r_retry + 2'd1;
                     r_lst       <= L_SEL;
                     r_csr_wen   <= 1'b1;
                     r_csr_addr  <= LP_CSR_SEL;
                     r_csr_wdata <= {29'b0, r_lyr};
                  end else if (w_ld_ok) begin
                     r_lst <= L_NEXT;
                  end else begin
                     r_tmo <= r_tmo + 32'd1;
                  end
               end
               L_NEXT: begin
                  r_retry <= '0;
                  if (w_lyr_next == r_num) begin
                     r_lst <= L_IDLE;
                  end else begin
                     r_lyr <= r_lyr + 3'd1;
                     r_lst <= L_WAITBANK;
                  end
               end
               default: ;
            endcase

            case (r_cst)
               C_WAIT: begin
                  if (r_bank_full[r_cly[0]]) begin
                     r_cst        <= C_RUN;
                     r_comp_start <= 1'b1;
                     r_comp_layer <= r_cly;
                     r_comp_bank  <= r_cly[0];
                  end
               end
               C_RUN: begin
                  if (comp_done) begin
                     if (w_cly_next == r_num) begin
                        r_seq_done <= 1'b1;
                        r_seq_busy <= 1'b0;
                        r_cst      <= C_IDLE;
                     end else begin
                        r_cly <= r_cly + 3'd1;
                        r_cst <= C_WAIT;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign dma_csr_addr  = r_csr_addr;
   assign dma_csr_wen   = r_csr_wen;
   assign dma_csr_wdata = r_csr_wdata;
   assign load_bank     = r_load_bank;
   assign comp_start    = r_comp_start;
   assign comp_layer    = r_comp_layer;
   assign comp_bank     = r_comp_bank;
   assign seq_busy      = r_seq_busy;
   assign seq_done      = r_seq_done;
   assign seq_error     = r_seq_error;
   assign retry_count   = r_retry;

endmodule

// File: tb/tb_bsr_layer_sequencer.sv
// Directed bench for bsr_layer_sequencer: scripted DMA/compute responders, hand-computed cycle
// expectations for CSR writes, comp_start pulses and seq_done/seq_error.
module tb_bsr_layer_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seq_start = 1'b0;
   logic        seq_abort = 1'b0;
   logic [3:0]  cfg_num_layers = '0;
   logic        cfg_word_mode = 1'b0;
   logic [7:0]  dma_csr_addr;
   logic        dma_csr_wen;
   logic [31:0] dma_csr_wdata;
   logic        dma_busy = 1'b0;
   logic        dma_done = 1'b0;
   logic        dma_error = 1'b0;
   logic        load_bank;
   logic        comp_start;
   logic [2:0]  comp_layer;
   logic        comp_bank;
   logic        comp_done = 1'b0;
   logic        seq_busy;
   logic        seq_done;
   logic        seq_error;
   logic [1:0]  retry_count;

   bsr_layer_sequencer #(
      .MAX_LAYERS(8),
      .MAX_RETRY(3),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .clk(clk), .rst_n(rst_n), .seq_start(seq_start), .seq_abort(seq_abort),
      .cfg_num_layers(cfg_num_layers), .cfg_word_mode(cfg_word_mode),
      .dma_csr_addr(dma_csr_addr), .dma_csr_wen(dma_csr_wen), .dma_csr_wdata(dma_csr_wdata),
      .dma_busy(dma_busy), .dma_done(dma_done), .dma_error(dma_error),
      .load_bank(load_bank), .comp_start(comp_start), .comp_layer(comp_layer),
      .comp_bank(comp_bank), .comp_done(comp_done), .seq_busy(seq_busy),
      .seq_done(seq_done), .seq_error(seq_error), .retry_count(retry_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Per-START DMA response: 0 done, 1 error, 2 silent (timeout), 3 done+error.
   int          kinds[16];
   logic [7:0]  a_addr[64];
   logic [31:0] a_data[64];
   int          a_cyc[64];
   logic        a_lb[64];
   int          s_cyc[16];
   logic [2:0]  s_layer[16];
   logic        s_bank[16];
   int          n_csr, n_cs, n_done, done_cyc, err_cyc, max_retry;
   logic        busy_first, busy_pre, busy_ab;
   logic [1:0]  bank_pre, bank_ab;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ck(input string tag, input int i, input int c, input logic [7:0] a,
                     input logic [31:0] d);
      int c0;
      c0 = a_cyc[i];
      chk($sformatf("%s_csr[%0d]", tag, i), {16'(c0), a_addr[i], a_data[i]}, {16'(c), a, d});
   endtask

   task automatic cks(input string tag, input int i, input int c, input logic [2:0] l,
                      input logic b);
      int c0;
      c0 = s_cyc[i];
      chk($sformatf("%s_cstart[%0d]", tag, i), {16'(c0), s_layer[i], s_bank[i]},
          {16'(c), l, b});
   endtask

   // Cycle 0 carries seq_start; every observation is stamped relative to it.
   task automatic run(input logic [3:0] num, input logic wm, input int dma_dly, input int comp_dly,
                      input int abort_at, input int stray_at, input int restart_at,
                      input int limit);
      int rel, dma_t, comp_t, nstart, kind_now;
      for (int i = 0; i < 64; i++) begin
         a_addr[i] = '0; a_data[i] = '0; a_cyc[i] = -1; a_lb[i] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         s_cyc[i] = -1; s_layer[i] = '0; s_bank[i] = 1'b0;
      end
      n_csr = 0; n_cs = 0; n_done = 0; done_cyc = -1; err_cyc = -1; max_retry = 0;
      busy_first = 1'b0; busy_pre = 1'b0; busy_ab = 1'b1; bank_pre = '0; bank_ab = '1;
      dma_t = -1; comp_t = -1; nstart = 0; kind_now = 0;
      cfg_num_layers = num;
      cfg_word_mode  = wm;
      seq_start      = 1'b1;
      tick();
      seq_start = 1'b0;
      rel = 1;
      while (rel < limit) begin
         if (dma_csr_wen && n_csr < 64) begin
            a_addr[n_csr] = dma_csr_addr;
            a_data[n_csr] = dma_csr_wdata;
            a_cyc[n_csr]  = rel;
            a_lb[n_csr]   = load_bank;
            n_csr++;
            if (dma_csr_addr == 8'h51) begin
               dma_t    = rel + dma_dly;
               kind_now = kinds[nstart % 16];
               nstart++;
            end
         end
         if (comp_start && n_cs < 16) begin
            s_cyc[n_cs]   = rel;
            s_layer[n_cs] = comp_layer;
            s_bank[n_cs]  = comp_bank;
            n_cs++;
            comp_t = rel + comp_dly;
         end
         if (int'(retry_count) > max_retry) max_retry = int'(retry_count);
         if (rel == 1) busy_first = seq_busy;
         if (rel == abort_at) begin busy_pre = seq_busy; bank_pre = dut.r_bank_full; end
         if (rel == abort_at + 1) begin busy_ab = seq_busy; bank_ab = dut.r_bank_full; end
         if (seq_done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = rel;
         end
         if (seq_error && err_cyc < 0) err_cyc = rel;
         if (abort_at < 0 && (seq_done || seq_error)) break;
         dma_done       = (rel == dma_t) && (kind_now == 0 || kind_now == 3);
         dma_error      = (rel == dma_t) && (kind_now == 1 || kind_now == 3);
         comp_done      = (rel == comp_t) || (rel == stray_at);
         seq_abort      = (rel == abort_at);
         seq_start      = (rel == restart_at);
         cfg_num_layers = (rel == restart_at) ? 4'd0 : num;
         tick();
         rel++;
      end
      dma_done = 1'b0; dma_error = 1'b0; comp_done = 1'b0; seq_abort = 1'b0; seq_start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) kinds[i] = 0;
      repeat (3) tick();
      chk("reset_outs", {dma_csr_addr, dma_csr_wdata, dma_csr_wen, load_bank, comp_start,
                         comp_layer, comp_bank, seq_busy, seq_done, seq_error, retry_count}, '0);
      rst_n = 1'b1;
      tick();

      // 3 layers, fast DMA, overlap of load 1 with compute 0; stray seq_start while busy.
      run(4'd3, 1'b1, 5, 20, -1, -1, 20, 200);
      chk("t1_busy", busy_first, 1'b1);
      chk("t1_ncsr", n_csr, 6);
      ck("t1", 0, 1, 8'h50, 0);   ck("t1", 1, 2, 8'h51, 5);
      ck("t1", 2, 10, 8'h50, 1);  ck("t1", 3, 11, 8'h51, 5);
      ck("t1", 4, 31, 8'h50, 2);  ck("t1", 5, 32, 8'h51, 5);
      chk("t1_loadbank", {a_lb[0], a_lb[2], a_lb[4]}, 3'b010);
      chk("t1_ncs", n_cs, 3);
      cks("t1", 0, 9, 3'd0, 1'b0); cks("t1", 1, 31, 3'd1, 1'b1); cks("t1", 2, 53, 3'd2, 1'b0);
      chk("t1_done", done_cyc, 74);
      chk("t1_err", seq_error, 1'b0);

      // Slow compute: layer 2 load stalls until compute 0 frees bank 0; stray comp_done ignored.
      run(4'd3, 1'b0, 5, 500, -1, 5, -1, 2000);
      chk("t2_ncsr", n_csr, 6);
      ck("t2", 2, 10, 8'h50, 1);  ck("t2", 4, 511, 8'h50, 2); ck("t2", 5, 512, 8'h51, 1);
      cks("t2", 0, 9, 3'd0, 1'b0); cks("t2", 1, 511, 3'd1, 1'b1); cks("t2", 2, 1013, 3'd2, 1'b0);
      chk("t2_done", done_cyc, 1514);

      // Single error on layer 1 first attempt.
      kinds[1] = 1;
      run(4'd3, 1'b0, 5, 20, -1, -1, -1, 200);
      chk("t3_ncsr", n_csr, 8);
      ck("t3", 2, 10, 8'h50, 1);  ck("t3", 3, 11, 8'h51, 1);
      ck("t3", 4, 17, 8'h50, 1);  ck("t3", 5, 18, 8'h51, 1);
      ck("t3", 6, 31, 8'h50, 2);
      chk("t3_retry", max_retry, 1);
      cks("t3", 1, 31, 3'd1, 1'b1); cks("t3", 2, 53, 3'd2, 1'b0);
      chk("t3_done", done_cyc, 74);
      chk("t3_err", seq_error, 1'b0);

      // Four errors on layer 0 exhaust the retries.
      for (int i = 0; i < 16; i++) kinds[i] = 1;
      run(4'd3, 1'b0, 5, 20, -1, -1, -1, 200);
      chk("t4_ncsr", n_csr, 8);
      for (int k = 0; k < 4; k++) begin
         ck("t4", 2 * k, 1 + 7 * k, 8'h50, 0);
         ck("t4", 2 * k + 1, 2 + 7 * k, 8'h51, 1);
      end
      chk("t4_retry", max_retry, 3);
      chk("t4_errcyc", err_cyc, 29);
      chk("t4_err", seq_error, 1'b1);
      chk("t4_busy", seq_busy, 1'b0);
      chk("t4_ncs", n_cs, 0);
      chk("t4_ndone", n_done, 0);

      // Timeout after 50 cycles in L_WAIT, then done+error counted as error.
      for (int i = 0; i < 16; i++) kinds[i] = 0;
      kinds[0] = 2;
      kinds[1] = 3;
      run(4'd1, 1'b1, 5, 20, -1, -1, -1, 300);
      chk("t5_err_cleared", seq_error, 1'b0);
      chk("t5_ncsr", n_csr, 6);
      ck("t5", 1, 2, 8'h51, 5);   ck("t5", 2, 53, 8'h50, 0);  ck("t5", 3, 54, 8'h51, 5);
      ck("t5", 4, 60, 8'h50, 0);  ck("t5", 5, 61, 8'h51, 5);
      chk("t5_retry", max_retry, 2);
      cks("t5", 0, 68, 3'd0, 1'b0);
      chk("t5_done", done_cyc, 89);

      // Abort during layer 1 compute; late comp_done must not finish anything.
      for (int i = 0; i < 16; i++) kinds[i] = 0;
      run(4'd3, 1'b0, 5, 20, 40, -1, -1, 80);
      chk("t6_busy_pre", busy_pre, 1'b1);
      chk("t6_bank_pre", bank_pre, 2'b11);
      chk("t6_busy_ab", busy_ab, 1'b0);
      chk("t6_bank_ab", bank_ab, 2'b00);
      chk("t6_ncs", n_cs, 2);
      chk("t6_ndone", n_done, 0);
      chk("t6_ncsr", n_csr, 6);

      // Zero layers: seq_done one cycle after start, no CSR traffic.
      run(4'd0, 1'b0, 5, 20, -1, -1, -1, 10);
      chk("t7_done", done_cyc, 1);
      chk("t7_ncsr", n_csr, 0);
      chk("t7_ncs", n_cs, 0);

      // Layer count above the maximum clamps to 8.
      run(4'd15, 1'b0, 3, 4, -1, -1, -1, 200);
      chk("t8_ncsr", n_csr, 16);
      chk("t8_ncs", n_cs, 8);
      for (int k = 0; k < 8; k++) begin
         ck("t8", 2 * k, 1 + 7 * k, 8'h50, 32'(k));
         cks("t8", k, 7 + 7 * k, 3'(k), k[0]);
      end
      ck("t8", 15, 51, 8'h51, 1);
      chk("t8_done", done_cyc, 61);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
